// File: rtl/mac_pipe_acc.sv
// rtl/mac_pipe_acc.sv - pipelined multiply-accumulate with stall, clear and sticky overflow
// Optional input and product register stages feed an always-present accumulator stage.
module mac_pipe_acc #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 32,
  parameter int SIGNED    = 0,
  parameter int IN_REG    = 1,
  parameter int MULT_REG  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic [ACC_WIDTH-1:0] c,
  input  logic [1:0]           mode,
  input  logic                 hold,
  input  logic                 clr,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] y,
  output logic                 ovf
);

  localparam int PW  = A_WIDTH + B_WIDTH;
  localparam int MSB = ACC_WIDTH - 1;

  logic [A_WIDTH-1:0]   a_q, a_d;
  logic [B_WIDTH-1:0]   b_q, b_d;
  logic [ACC_WIDTH-1:0] c_q, c_d;
  logic [1:0]           mode_q, mode_d;
  logic                 v1_q, v1_d;

  logic [ACC_WIDTH-1:0] prod_q, prod_d;
  logic [ACC_WIDTH-1:0] c2_q, c2_d;
  logic [1:0]           mode2_q, mode2_d;
  logic                 v2_q, v2_d;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;

  logic [A_WIDTH-1:0]   s1_a;
  logic [B_WIDTH-1:0]   s1_b;
  logic [ACC_WIDTH-1:0] s1_c, s2_c;
  logic [1:0]           s1_mode, s2_mode;
  logic                 s1_v, s2_v;
  logic [ACC_WIDTH-1:0] prod_ext, s2_prod;
  logic [PW-1:0]        a_ext, b_ext, prod;
  logic [ACC_WIDTH:0]   sum, diff;
  logic                 add_ovf, sub_ovf;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    mode_d = mode_q;
    v1_d   = v1_q;
    if (clr) begin
      v1_d = 1'b0;
    end else if (!hold) begin
      a_d    = a;
      b_d    = b;
      c_d    = c;
      mode_d = mode;
      v1_d   = in_valid;
    end
  end

  assign s1_a    = (IN_REG != 0) ? a_q    : a;
  assign s1_b    = (IN_REG != 0) ? b_q    : b;
  assign s1_c    = (IN_REG != 0) ? c_q    : c;
  assign s1_mode = (IN_REG != 0) ? mode_q : mode;
  assign s1_v    = (IN_REG != 0) ? v1_q   : in_valid;

  // Low PW bits of the product are identical for signed and unsigned once operands are extended.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = PW'($signed(s1_a));
      b_ext = PW'($signed(s1_b));
    end else begin
      a_ext = PW'(s1_a);
      b_ext = PW'(s1_b);
    end
    prod = a_ext * b_ext;
    if (SIGNED != 0) prod_ext = ACC_WIDTH'($signed(prod));
    else             prod_ext = ACC_WIDTH'(prod);
  end

  always_comb begin
    prod_d  = prod_q;
    c2_d    = c2_q;
    mode2_d = mode2_q;
    v2_d    = v2_q;
    if (clr) begin
      v2_d = 1'b0;
    end else if (!hold) begin
      prod_d  = prod_ext;
      c2_d    = s1_c;
      mode2_d = s1_mode;
      v2_d    = s1_v;
    end
  end

  assign s2_prod = (MULT_REG != 0) ? prod_q  : prod_ext;
  assign s2_c    = (MULT_REG != 0) ? c2_q    : s1_c;
  assign s2_mode = (MULT_REG != 0) ? mode2_q : s1_mode;
  assign s2_v    = (MULT_REG != 0) ? v2_q    : s1_v;

  always_comb begin
    sum  = {1'b0, acc_q} + {1'b0, s2_prod};
    diff = {1'b0, acc_q} - {1'b0, s2_prod};
    if (SIGNED != 0) begin
      add_ovf = (acc_q[MSB] == s2_prod[MSB]) && (sum[MSB] != acc_q[MSB]);
      sub_ovf = (acc_q[MSB] != s2_prod[MSB]) && (diff[MSB] != acc_q[MSB]);
    end else begin
      add_ovf = sum[ACC_WIDTH];
      sub_ovf = diff[ACC_WIDTH];
    end
  end

  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (!hold && s2_v) begin
      out_valid_d = 1'b1;
      case (s2_mode)
        2'b00: begin
          acc_d = s2_prod;
          ovf_d = 1'b0;
        end
        2'b01: begin
          acc_d = sum[MSB:0];
          ovf_d = ovf_q | add_ovf;
        end
        2'b10: begin
          acc_d = diff[MSB:0];
          ovf_d = ovf_q | sub_ovf;
        end
        default: begin
          acc_d = s2_c;
          ovf_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      mode_q      <= '0;
      v1_q        <= 1'b0;
      prod_q      <= '0;
      c2_q        <= '0;
      mode2_q     <= '0;
      v2_q        <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      mode_q      <= mode_d;
      v1_q        <= v1_d;
      prod_q      <= prod_d;
      c2_q        <= c2_d;
      mode2_q     <= mode2_d;
      v2_q        <= v2_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = acc_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_pipe_acc.sv
// tb/tb_mac_pipe_acc.sv - directed bench for mac_pipe_acc across four parameter sets
// All instances share one stimulus stream; each step checks the instance it targets.
module tb_mac_pipe_acc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [31:0] c;
  logic [1:0]  mode;
  logic        hold;
  logic        clr;

  logic        ov0, ovf0, ovs, ovfs, ov16, ovf16, ov1, ovf1;
  logic [31:0] y0, ys, y1;
  logic [15:0] y16;

  int checks = 0;
  int errors = 0;

  mac_pipe_acc u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .mode(mode),
    .hold(hold), .clr(clr), .out_valid(ov0), .y(y0), .ovf(ovf0)
  );

  mac_pipe_acc #(.SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .mode(mode),
    .hold(hold), .clr(clr), .out_valid(ovs), .y(ys), .ovf(ovfs)
  );

  mac_pipe_acc #(.ACC_WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c[15:0]), .mode(mode),
    .hold(hold), .clr(clr), .out_valid(ov16), .y(y16), .ovf(ovf16)
  );

  mac_pipe_acc #(.IN_REG(0), .MULT_REG(0)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .mode(mode),
    .hold(hold), .clr(clr), .out_valid(ov1), .y(y1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                       input logic [31:0] cc, input logic [1:0] m);
    in_valid = v;
    a        = aa;
    b        = bb;
    c        = cc;
    mode     = m;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b0;
    hold = 1'b0;
    clr  = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 32'd0, 2'd0);
    repeat (2) tick();
    chk("rst_y", y0, 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    chk("rst_ov", 32'(ov0), 32'd0);
    chk("rst_ys", ys, 32'd0);
    #2 rst = 1'b1;
    tick();

    // single multiply, latency 3
    drive(1'b1, 8'd200, 8'd100, 32'd0, 2'b00);
    tick();
    drive(1'b0, 8'd0, 8'd0, 32'd0, 2'b00);
    chk("t1_ov_c1", 32'(ov0), 32'd0);
    tick();
    chk("t1_ov_c2", 32'(ov0), 32'd0);
    tick();
    chk("t1_ov_c3", 32'(ov0), 32'd1);
    chk("t1_y", y0, 32'd20000);
    chk("t1_ovf", 32'(ovf0), 32'd0);
    tick();
    chk("t1_ov_c4", 32'(ov0), 32'd0);
    chk("t1_y_hold", y0, 32'd20000);

    // back-to-back multiply, accumulate, subtract
    drive(1'b1, 8'd3, 8'd4, 32'd0, 2'b00);
    tick();
    drive(1'b1, 8'd5, 8'd6, 32'd0, 2'b01);
    tick();
    drive(1'b1, 8'd2, 8'd2, 32'd0, 2'b10);
    tick();
    drive(1'b0, 8'd0, 8'd0, 32'd0, 2'b00);
    chk("t2_ov_a", 32'(ov0), 32'd1);
    chk("t2_y_a", y0, 32'd12);
    tick();
    chk("t2_ov_b", 32'(ov0), 32'd1);
    chk("t2_y_b", y0, 32'd42);
    tick();
    chk("t2_ov_c", 32'(ov0), 32'd1);
    chk("t2_y_c", y0, 32'd38);
    chk("t2_ovf", 32'(ovf0), 32'd0);

    // signed multiply then subtract of a positive product
    drive(1'b1, 8'hFD, 8'h05, 32'd0, 2'b00);
    tick();
    drive(1'b1, 8'h80, 8'h80, 32'd0, 2'b10);
    tick();
    drive(1'b0, 8'd0, 8'd0, 32'd0, 2'b00);
    tick();
    chk("t3_ov", 32'(ovs), 32'd1);
    chk("t3_y_a", ys, 32'hFFFF_FFF1);
    tick();
    chk("t3_y_b", ys, 32'hFFFF_BFF1);
    chk("t3_ovf", 32'(ovfs), 32'd0);

    // 16-bit accumulator: load, overflowing add, sticky flag, clear
    drive(1'b1, 8'd0, 8'd0, 32'h0000_FFF0, 2'b11);
    tick();
    drive(1'b1, 8'd1, 8'd32, 32'd0, 2'b01);
    tick();
    drive(1'b1, 8'd1, 8'd1, 32'd0, 2'b01);
    tick();
    drive(1'b0, 8'd0, 8'd0, 32'd0, 2'b00);
    chk("t4_load", {16'h0, y16}, 32'h0000_FFF0);
    chk("t4_ov", 32'(ov16), 32'd1);
    tick();
    chk("t4_wrap", {16'h0, y16}, 32'h0000_0010);
    chk("t4_ovf_set", 32'(ovf16), 32'd1);
    tick();
    chk("t4_add", {16'h0, y16}, 32'h0000_0011);
    chk("t4_ovf_sticky", 32'(ovf16), 32'd1);
    drive(1'b1, 8'd7, 8'd7, 32'd0, 2'b00);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 32'd0, 2'b00);
    chk("clr_y16", {16'h0, y16}, 32'd0);
    chk("clr_ovf16", 32'(ovf16), 32'd0);
    chk("clr_y0", y0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("clr_discard_ov", 32'(ov0), 32'd0);
    end
    chk("clr_discard_y", y0, 32'd0);

    // hold for two cycles; op offered during hold must be ignored
    drive(1'b1, 8'd10, 8'd11, 32'd0, 2'b00);
    tick();
    hold = 1'b1;
    drive(1'b1, 8'd9, 8'd9, 32'd0, 2'b00);
    chk("hold_ov_c1", 32'(ov0), 32'd0);
    tick();
    chk("hold_ov_c2", 32'(ov0), 32'd0);
    tick();
    hold = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 32'd0, 2'b00);
    chk("hold_ov_c3", 32'(ov0), 32'd0);
    tick();
    chk("hold_ov_c4", 32'(ov0), 32'd0);
    tick();
    chk("hold_ov_c5", 32'(ov0), 32'd1);
    chk("hold_y", y0, 32'd110);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_no_second_op", 32'(ov0), 32'd0);
    end
    chk("hold_y_final", y0, 32'd110);

    // no pipeline registers: latency 1
    drive(1'b1, 8'd12, 8'd13, 32'd0, 2'b00);
    tick();
    drive(1'b0, 8'd0, 8'd0, 32'd0, 2'b00);
    chk("l1_ov", 32'(ov1), 32'd1);
    chk("l1_y", y1, 32'd156);
    chk("l1_ovf", 32'(ovf1), 32'd0);
    tick();
    chk("l1_ov_pulse", 32'(ov1), 32'd0);
    repeat (3) tick();
    chk("pre_rst_y", y0, 32'd156);

    // asynchronous reset during an in-flight op
    drive(1'b1, 8'd50, 8'd50, 32'd0, 2'b00);
    tick();
    drive(1'b0, 8'd0, 8'd0, 32'd0, 2'b00);
    rst = 1'b0;
    #1;
    chk("arst_y", y0, 32'd0);
    chk("arst_ovf", 32'(ovf0), 32'd0);
    chk("arst_ov", 32'(ov0), 32'd0);
    tick();
    chk("arst_ov_c2", 32'(ov0), 32'd0);
    tick();
    chk("arst_ov_c3", 32'(ov0), 32'd0);
    chk("arst_y_c3", y0, 32'd0);
    #2 rst = 1'b1;
    tick();
    drive(1'b1, 8'd3, 8'd3, 32'd0, 2'b00);
    tick();
    drive(1'b0, 8'd0, 8'd0, 32'd0, 2'b00);
    chk("post_rst_ov_1", 32'(ov0), 32'd0);
    tick();
    chk("post_rst_ov_2", 32'(ov0), 32'd0);
    tick();
    chk("post_rst_ov_3", 32'(ov0), 32'd1);
    chk("post_rst_y", y0, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
